// File: rtl/srff_bank_ctrl.sv
// Round-robin sequencer for a bank of gated SR latches: SETUP -> PULSE -> HOLD -> ACK per grant.
// Optional readback check of the latch bank enabled by defining SRFF_READBACK_EN.
module srff_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int PULSE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   op_i,
    input  logic [NREQ*W-1:0] mask_i,
    input  logic [W-1:0]      q_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              busy_o,
    output logic [W-1:0]      s_o,
    output logic [W-1:0]      r_o,
    output logic              c_o,
    output logic              err_o
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic              op_q, op_d;
    logic [W-1:0]      mask_q, mask_d;
    logic [W-1:0]      s_q, s_d;
    logic [W-1:0]      r_q, r_d;
    logic              c_q, c_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              found;
    logic [GW-1:0]     gsel;
    logic              drive;
    int                idx;

    // First active requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                gsel  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_SETUP;
                    gnt_d   = gsel;
                    op_d    = op_i[gsel];
                    mask_d  = mask_i[int'(gsel)*W +: W];
                    ptr_d   = (gsel == GW'(NREQ - 1)) ? '0 : gsel + GW'(1);
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
            ST_PULSE: begin
                if (cnt_q == CW'(PULSE - 1)) state_d = ST_HOLD;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            ST_HOLD:  state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so every pin comes straight from a flop.
        drive  = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        s_d    = (drive && op_d)  ? mask_d : '0;
        r_d    = (drive && !op_d) ? mask_d : '0;
        c_d    = (state_d == ST_PULSE);
        ack_d  = (state_d == ST_ACK) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_d) : '0;
        busy_d = (state_d != ST_IDLE);
    end

`ifdef SRFF_READBACK_EN
    // Latch contents are sampled on the HOLD->ACK edge so err lines up with ack.
    always_comb err_d = (state_q == ST_HOLD) && ((q_i & mask_q) != (op_q ? mask_q : '0));
`else
    logic unused_q;
    assign unused_q = ^q_i;
    assign err_d    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        mask_q <= mask_d;
    end

    assign s_o    = s_q;
    assign r_o    = r_q;
    assign c_o    = c_q;
    assign ack_o  = ack_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule
